// File: rtl/autoseller_pkg.sv
// autoseller_pkg: shared state encoding and defaults for the autoseller front-end.
// Rev 1.0
`default_nettype none

package autoseller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam int DEF_MONEY_W  = 6;
  localparam int DEF_TYPE_W   = 2;
  localparam int REFUND_DRINK = 0;

endpackage

`default_nettype wire

// File: rtl/autoseller_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning ptr, ptr+1, ... mod N_REQ.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW:0]        sum;

  // Rotate so bit 0 of rot is the slot at ptr; first set bit of rot wins.
  assign dbl = {req, req};
  assign rot = N_REQ'(dbl >> ptr);

  always_comb begin
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW+1)'(k);
      end
    end
    if (sum >= (IW+1)'(N_REQ)) begin
      sum = sum - (IW+1)'(N_REQ);
    end
    idx = IW'(sum);
    if (any) begin
      grant = N_REQ'(1) << idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/autoseller_arbiter.sv
// autoseller_arbiter: shares one autoseller among N_REQ coin slots, with timeout refund.
// Rev 1.0
`default_nettype none

module autoseller_arbiter
  import autoseller_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MONEY_W = DEF_MONEY_W,
  parameter int TYPE_W  = DEF_TYPE_W,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*MONEY_W-1:0]   money_i,
  input  logic [N_REQ*TYPE_W-1:0]    type_i,
  output logic [N_REQ-1:0]           accept_o,
  output logic [N_REQ-1:0]           done_o,
  output logic [MONEY_W-1:0]         change_o,
  output logic [TYPE_W-1:0]          drink_o,
  output logic                       err_o,
  output logic                       busy_o,
  input  logic                       seller_ready_i,
  output logic                       seller_enable_o,
  output logic [MONEY_W-1:0]         seller_money_o,
  output logic [TYPE_W-1:0]          seller_type_o,
  input  logic                       seller_valid_i,
  input  logic [MONEY_W-1:0]         seller_change_i,
  input  logic [TYPE_W-1:0]          seller_drink_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int TMW = $clog2(TIMEOUT+1);

  state_t             state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [MONEY_W-1:0] lat_money, lat_money_nxt;
  logic [TYPE_W-1:0]  lat_type, lat_type_nxt;
  logic [TMW-1:0]     timer, timer_nxt;

  logic [N_REQ-1:0]   accept_nxt, done_nxt;
  logic [MONEY_W-1:0] change_nxt, smoney_nxt;
  logic [TYPE_W-1:0]  drink_nxt, stype_nxt;
  logic               err_nxt, busy_nxt, enable_nxt;

  logic [N_REQ-1:0]   arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_i),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      gidx            <= '0;
      lat_money       <= '0;
      lat_type        <= '0;
      timer           <= '0;
      accept_o        <= '0;
      done_o          <= '0;
      change_o        <= '0;
      drink_o         <= '0;
      err_o           <= 1'b0;
      busy_o          <= 1'b0;
      seller_enable_o <= 1'b0;
      seller_money_o  <= '0;
      seller_type_o   <= '0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      gidx            <= gidx_nxt;
      lat_money       <= lat_money_nxt;
      lat_type        <= lat_type_nxt;
      timer           <= timer_nxt;
      accept_o        <= accept_nxt;
      done_o          <= done_nxt;
      change_o        <= change_nxt;
      drink_o         <= drink_nxt;
      err_o           <= err_nxt;
      busy_o          <= busy_nxt;
      seller_enable_o <= enable_nxt;
      seller_money_o  <= smoney_nxt;
      seller_type_o   <= stype_nxt;
    end
  end

  // Every output is a one-cycle pulse or a value qualified by one, so all default to 0.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gidx_nxt      = gidx;
    lat_money_nxt = lat_money;
    lat_type_nxt  = lat_type;
    timer_nxt     = timer;
    accept_nxt    = '0;
    done_nxt      = '0;
    change_nxt    = '0;
    drink_nxt     = '0;
    err_nxt       = 1'b0;
    enable_nxt    = 1'b0;
    smoney_nxt    = '0;
    stype_nxt     = '0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          accept_nxt    = arb_grant;
          gidx_nxt      = arb_idx;
          lat_money_nxt = money_i[arb_idx*MONEY_W +: MONEY_W];
          lat_type_nxt  = type_i[arb_idx*TYPE_W +: TYPE_W];
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (seller_ready_i) begin
          enable_nxt = 1'b1;
          smoney_nxt = lat_money;
          stype_nxt  = lat_type;
          timer_nxt  = '0;
          state_nxt  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        timer_nxt = timer + 1'b1;
        // A response on the timeout edge still wins over the refund.
        if (seller_valid_i) begin
          done_nxt   = N_REQ'(1) << gidx;
          change_nxt = seller_change_i;
          drink_nxt  = seller_drink_i;
          state_nxt  = RESP;
        end else if (timer == TMW'(TIMEOUT-1)) begin
          done_nxt   = N_REQ'(1) << gidx;
          change_nxt = lat_money;
          drink_nxt  = TYPE_W'(REFUND_DRINK);
          err_nxt    = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        ptr_nxt   = (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_autoseller_arbiter.sv
// tb_autoseller_arbiter: directed and random checks against a transaction-level model.
// Rev 1.0
`default_nettype none

module tb_autoseller_arbiter;

  localparam int N  = 4;
  localparam int MW = 6;
  localparam int TW = 2;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*MW-1:0] money;
  logic [N*TW-1:0] dtype;
  logic            ready, valid;
  logic [MW-1:0]   schange;
  logic [TW-1:0]   sdrink;

  logic [N-1:0]    accept, done;
  logic [MW-1:0]   change, smoney;
  logic [TW-1:0]   drink, stype;
  logic            err, busy, enable;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;

  autoseller_arbiter #(.N_REQ(N), .MONEY_W(MW), .TYPE_W(TW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req),
    .money_i         (money),
    .type_i          (dtype),
    .accept_o        (accept),
    .done_o          (done),
    .change_o        (change),
    .drink_o         (drink),
    .err_o           (err),
    .busy_o          (busy),
    .seller_ready_i  (ready),
    .seller_enable_o (enable),
    .seller_money_o  (smoney),
    .seller_type_o   (stype),
    .seller_valid_i  (valid),
    .seller_change_i (schange),
    .seller_drink_i  (sdrink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 free, 1 holding a customer until the seller is
  // ready, 2 seller working, 3 handing the result back.
  int            m_phase, m_ptr, m_g, m_elapsed;
  logic [MW-1:0] m_money;
  logic [TW-1:0] m_type;
  logic [N-1:0]  e_accept, e_done;
  logic [MW-1:0] e_change, e_smoney;
  logic [TW-1:0] e_drink, e_stype;
  logic          e_err, e_busy, e_enable, found;

  always @(posedge clk or posedge reset) begin
    e_accept = '0; e_done = '0; e_change = '0; e_smoney = '0;
    e_drink = '0; e_stype = '0; e_err = 1'b0; e_enable = 1'b0;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_g = 0; m_elapsed = 0; m_money = '0; m_type = '0;
      e_busy = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && req[2'((m_ptr + k) % N)]) begin
              found = 1'b1;
              m_g = (m_ptr + k) % N;
            end
          end
          if (found) begin
            e_accept = N'(1) << m_g;
            m_money  = money[m_g*MW +: MW];
            m_type   = dtype[m_g*TW +: TW];
            m_phase  = 1;
          end
        end
        1: if (ready) begin
          e_enable = 1'b1; e_smoney = m_money; e_stype = m_type;
          m_elapsed = 0; m_phase = 2;
        end
        2: begin
          if (valid) begin
            e_done = N'(1) << m_g; e_change = schange; e_drink = sdrink; m_phase = 3;
          end else if (m_elapsed == TO - 1) begin
            e_done = N'(1) << m_g; e_change = m_money; e_err = 1'b1; m_phase = 3;
          end
          m_elapsed = m_elapsed + 1;
        end
        default: begin
          m_ptr = (m_g + 1) % N;
          m_phase = 0;
        end
      endcase
      e_busy = (m_phase != 0);
    end
  end

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      chk("cyc_accept", 32'(accept), 32'(e_accept));
      chk("cyc_done",   32'(done),   32'(e_done));
      chk("cyc_change", 32'(change), 32'(e_change));
      chk("cyc_drink",  32'(drink),  32'(e_drink));
      chk("cyc_err",    32'(err),    32'(e_err));
      chk("cyc_busy",   32'(busy),   32'(e_busy));
      chk("cyc_enable", 32'(enable), 32'(e_enable));
      chk("cyc_smoney", 32'(smoney), 32'(e_smoney));
      chk("cyc_stype",  32'(stype),  32'(e_stype));
    end
  end

  always @(negedge clk) if (enable) en_cnt++;

  task automatic wait_for(input int sel, input int limit, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = (accept != '0);
        1:       hit = enable;
        default: hit = (done != '0);
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_timeout sel=%0d: got no event expected event within %0d cycles", sel, limit);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic respond(input logic [MW-1:0] c, input logic [TW-1:0] d);
    int n;
    valid = 1'b1; schange = c; sdrink = d;
    wait_for(2, 5, n);
    valid = 1'b0;
  endtask

  logic [N-1:0] order [5];
  int           slot  [5];
  int n, en_base, vdiv;
  bit ok;

  initial begin
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    slot  = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; money = '0; dtype = '0;
    ready = 1'b0; valid = 1'b0; schange = '0; sdrink = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({accept, done, change, drink, err, busy, enable, smoney, stype}), 32'd0);
    reset = 1'b0;

    // Single request
    @(negedge clk);
    req = 4'b0001; money[0 +: MW] = 6'h1E; dtype[0 +: TW] = 2'b10; ready = 1'b1;
    wait_for(0, 10, n);
    chk("t1_accept", 32'(accept), 32'h1);
    chk("t1_accept_lat", n, 1);
    req = '0;
    wait_for(1, 10, n);
    chk("t1_smoney", 32'(smoney), 32'h1E);
    chk("t1_stype", 32'(stype), 32'h2);
    repeat (2) @(negedge clk);
    valid = 1'b1; schange = 6'd5; sdrink = 2'b10;
    @(negedge clk);
    valid = 1'b0;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_change", 32'(change), 32'd5);
    chk("t1_drink", 32'(drink), 32'h2);
    chk("t1_err", 32'(err), 32'd0);

    // Round robin with all requesting
    do_reset();
    en_base = en_cnt;
    for (int k = 0; k < N; k++) money[k*MW +: MW] = MW'(10 + k);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_for(0, 20, n);
      chk("t2_order", 32'(accept), 32'(order[t]));
      if (t == 4) req = '0;
      wait_for(1, 10, n);
      chk("t2_smoney", 32'(smoney), 32'(10 + slot[t]));
      respond(MW'(t), TW'(t));
    end
    chk("t2_enables", en_cnt - en_base, 5);

    // Seller not ready for 10 cycles
    ready = 1'b0; req = 4'b0010; money[MW +: MW] = 6'h11;
    wait_for(0, 20, n);
    req = '0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (enable || !busy) ok = 1'b0;
    end
    chk("t3_hold", 32'(ok), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("t3_enable", 32'(enable), 32'd1);
    @(negedge clk);
    chk("t3_pulse", 32'(enable), 32'd0);
    respond(6'd1, 2'd1);

    // Timeout refund
    req = 4'b0001; money[0 +: MW] = 6'h28;
    wait_for(0, 20, n);
    req = '0;
    wait_for(1, 10, n);
    wait_for(2, 40, n);
    chk("t4_latency", n, 32);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_change", 32'(change), 32'h28);
    chk("t4_drink", 32'(drink), 32'd0);
    chk("t4_err", 32'(err), 32'd1);

    // Response on the timeout edge, then spurious valid in IDLE
    req = 4'b0010; money[MW +: MW] = 6'h33;
    wait_for(0, 20, n);
    req = '0;
    wait_for(1, 10, n);
    repeat (31) @(negedge clk);
    valid = 1'b1; schange = 6'd7; sdrink = 2'd3;
    @(negedge clk);
    valid = 1'b0;
    chk("t5_done", 32'(done), 32'h2);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_change", 32'(change), 32'd7);
    chk("t5_drink", 32'(drink), 32'd3);
    ok = 1'b1;
    valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done != '0) ok = 1'b0;
    end
    valid = 1'b0;
    chk("t5_spurious", 32'(ok), 32'd1);

    // Reset during WAIT_RSP
    req = 4'b0100; money[2*MW +: MW] = 6'h15;
    wait_for(0, 20, n);
    req = '0;
    wait_for(1, 10, n);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("t6_async", 32'({accept, done, change, drink, err, busy, enable, smoney, stype}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) ok = 1'b0;
    end
    chk("t6_nodone", 32'(ok), 32'd1);
    req = 4'b1111;
    wait_for(0, 10, n);
    chk("t6_ptr0", 32'(accept), 32'h1);
    req = '0;
    wait_for(1, 10, n);
    respond(6'd2, 2'd2);
    req = 4'b0100;
    wait_for(0, 10, n);
    chk("t6_accept", 32'(accept), 32'h4);
    req = '0;
    wait_for(1, 10, n);
    respond(6'd3, 2'd1);

    // Randomized traffic, checked every cycle by the model comparison
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      vdiv    = (cyc < 1000) ? 3 : ((cyc < 2000) ? 20 : 60);
      reset   = (($urandom % 500) == 0);
      req     = (($urandom % 3) == 0) ? '0 : N'($urandom);
      money   = (N*MW)'($urandom);
      dtype   = (N*TW)'($urandom);
      ready   = (($urandom % 4) != 0);
      valid   = (($urandom % vdiv) == 0);
      schange = MW'($urandom);
      sdrink  = TW'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; req = '0; valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/autoseller_arbiter.md
Name: autoseller_arbiter

Overview:
Round-robin front-end that shares one autoseller between N_REQ customer requesters (coin slots).
- Accepts one request at a time and latches its money/drink type.
- Issues exactly one enable pulse to the seller once the seller is ready, then waits for the seller's result.
- Returns change/drink to the granted requester with a one-cycle done pulse; if the seller does not answer within TIMEOUT cycles, refunds the full amount.

Parameters:
N_REQ, 4, number of requesters (2..8)
MONEY_W, 6, money/change width
TYPE_W, 2, drink type width
TIMEOUT, 32, max cycles in WAIT_RSP before refund (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  N_REQ  per-requester request level; held until accept_o[k]
money_i  in  N_REQ*MONEY_W  packed money, slot k at [k*MONEY_W +: MONEY_W]
type_i  in  N_REQ*TYPE_W  packed drink type, same packing
accept_o  out  N_REQ  one-hot, one-cycle pulse: request k latched
done_o  out  N_REQ  one-hot, one-cycle pulse: result for k valid
change_o  out  MONEY_W  result change, valid with done_o
drink_o  out  TYPE_W  result drink, valid with done_o
err_o  out  1  timeout refund flag, valid with done_o
busy_o  out  1  high whenever state != IDLE
seller_ready_i  in  1  seller ready_o
seller_enable_o  out  1  seller enable_i, one-cycle pulse
seller_money_o  out  MONEY_W  seller money_i
seller_type_o  out  TYPE_W  seller drinktype_i
seller_valid_i  in  1  seller enable_o (result valid)
seller_change_i  in  MONEY_W  seller change_o
seller_drink_i  in  TYPE_W  seller drink_o

Behaviour:
- Reset (async, active-high):
  - state=IDLE, ptr=0, timer=0.
  - All outputs 0, including seller_money_o/seller_type_o.
  - Reset mid-transaction drops the transaction silently; no done_o pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - If req_i != 0, grant the first set bit scanning ptr, ptr+1, ... mod N_REQ.
  - Registered at the next edge: accept_o[g]=1, latch money/type[g] and g. Go to ISSUE.
- ISSUE:
  - On an edge with seller_ready_i=1: seller_enable_o<=1, seller_money_o/type_o<=latched values, timer<=0. Go to WAIT_RSP.
  - Otherwise wait indefinitely; seller_enable_o stays 0.
- WAIT_RSP:
  - seller_enable_o, seller_money_o and seller_type_o return to 0 after one cycle, so the pulse is exactly one cycle.
  - timer increments each cycle.
  - On seller_valid_i=1: capture seller_change_i/seller_drink_i, err<=0, go to RESP.
  - Else if timer==TIMEOUT-1: change<=latched money, drink<=0, err<=1, go to RESP.
  - If a valid response and the timeout occur on the same edge, the response wins (err=0).
- RESP:
  - Outputs registered on entry, so done_o[g]=1 with change_o/drink_o/err_o for exactly the first cycle in RESP.
  - On that same edge: ptr<=(g+1) mod N_REQ, go to IDLE.
  - change_o/drink_o/err_o return to 0 when done_o drops.
- Latency:
  - accept_o follows req_i by 1 cycle (from IDLE).
  - seller_enable_o follows accept_o by at least 1 cycle.
  - done_o follows seller_valid_i by 1 cycle.
- Fairness: a requester continuously asserting req_i is accepted within N_REQ transactions.
- Requests asserted while busy are held by the requester; no queueing inside the block.
- seller_valid_i outside WAIT_RSP is ignored (no state change).
- req_i dropped before accept_o is allowed; the arbitration sample at the IDLE edge decides.
- Timer width: $clog2(TIMEOUT+1); no wrap possible.

Decomposition:
- Package autoseller_pkg: state encoding (IDLE, ISSUE, WAIT_RSP, RESP), MONEY_W/TYPE_W defaults, refund drink code 0.
- One sub-module: rr_arbiter (N_REQ request vector + ptr -> one-hot grant + index, combinational). FSM, timer and datapath registers stay in the top.

Test Plan:
- Single request: req_i=0001, money=0x1E, type=2'b10; seller ready, returns change=5, drink=10 after 3 cycles -> accept_o=0001 for 1 cycle, one seller_enable_o pulse carrying 0x1E/10, done_o=0001 with change_o=5, drink_o=10, err_o=0.
- All four requesting continuously, ptr=0 -> accept order 0,1,2,3,0. Each seller_money_o matches that slot's money_i. Exactly one seller_enable_o per transaction.
- seller_ready_i low for 10 cycles after accept -> seller_enable_o stays 0, then pulses once on the edge after ready rises. busy_o high throughout.
- No seller response, TIMEOUT=32, money=0x28 -> done_o pulses 32 cycles after the seller_enable_o cycle with change_o=0x28, drink_o=00, err_o=1.
- seller_valid_i in the same cycle the timer hits TIMEOUT-1 -> err_o=0, seller values returned. A spurious seller_valid_i in IDLE produces no done_o.
- Reset asserted during WAIT_RSP -> all outputs 0 immediately (asynchronous), ptr=0, no done_o. After release, a new req_i=0100 is accepted normally.
